// File: rtl/hh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hh_pkg
// Description : Shared types and default constants for the membrane potential
//               datapath and the ionic current blocks that consume V.
// Revision    : 1.0 - initial release
// ============================================================================
package hh_pkg;

    // Integration step sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        MUL   = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Potentials and currents are signed 16-bit, potentials in mV*10
    typedef logic signed [15:0] pot_t;
    typedef logic signed [15:0] cur_t;

    // Default resting, threshold and post-spike potentials (mV*10)
    localparam pot_t C_V_INIT  = pot_t'(-650);
    localparam pot_t C_V_TH    = pot_t'(0);
    localparam pot_t C_V_RESET = pot_t'(-700);

endpackage
`default_nettype wire

// File: rtl/membrane_update_if.sv
`default_nettype none
// ============================================================================
// Module      : membrane_update_if
// Description : Step request, operand and result bundle of membrane_update.
//               The master side issues steps; the slave side is the block.
// Revision    : 1.0 - initial release
// ============================================================================
interface membrane_update_if;
    import hh_pkg::*;

    logic        start;
    cur_t        dt;
    cur_t        I_ext;
    cur_t        I_NA;
    cur_t        I_K;
    cur_t        I_L;
    pot_t        V;
    logic        busy;
    logic        done;
    logic        spike;
    logic [15:0] spike_count;

    modport master (
        output start, dt, I_ext, I_NA, I_K, I_L,
        input  V, busy, done, spike, spike_count
    );

    modport slave (
        input  start, dt, I_ext, I_NA, I_K, I_L,
        output V, busy, done, spike, spike_count
    );

endinterface
`default_nettype wire

// File: rtl/sat_s36_to_s16.sv
`default_nettype none
// ============================================================================
// Module      : sat_s36_to_s16
// Description : Clamps a signed 36-bit value into the signed 16-bit range
//               [-32768, 32767]. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_s36_to_s16 (
    input  wire logic signed [35:0] in_i,
    output logic signed [15:0]      out_o
);

    // In range exactly when bits 35..15 are all copies of the sign bit
    always_comb begin
        out_o = in_i[15:0];
        if (in_i[35:15] != {21{in_i[35]}}) begin
            out_o = in_i[35] ? 16'sh8000 : 16'sh7FFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/membrane_update.sv
`default_nettype none
// ============================================================================
// Module      : membrane_update
// Description : Forward-Euler membrane potential integrator.
//               V += (dt * (I_ext - I_NA - I_K - I_L)) >>> C_SHIFT,
//               saturated to 16 bits, with upward threshold spike detection
//               and a wrapping spike counter. Four-cycle step.
//               Optional feature macro: MEMBRANE_SPIKE_RESET_EN
//               (when defined, a spiking step writes V_RESET to V).
// Revision    : 1.0 - initial release
// ============================================================================
module membrane_update
    import hh_pkg::*;
#(
    parameter pot_t V_INIT  = C_V_INIT,
    parameter int   C_SHIFT = 4,
    parameter pot_t V_TH    = C_V_TH,
    parameter pot_t V_RESET = C_V_RESET
) (
    input  wire logic          clk,
    input  wire logic          rst,
    membrane_update_if.slave   bus
);

    state_t             state_q, state_d;
    cur_t               dt_q, iext_q, ina_q, ik_q, il_q;
    logic signed [17:0] net_q;
    logic signed [33:0] delta_q;
    pot_t               V_q;
    logic               done_q;
    logic               spike_q;
    logic [15:0]        count_q;

    logic signed [17:0] w_net;
    logic signed [33:0] w_prod;
    logic signed [33:0] w_delta;
    logic signed [35:0] w_sum;
    pot_t               w_v_sat;
    pot_t               w_v_next;
    logic               w_spike;

    // Sign-extend every current to 18 bits; three 16-bit subtractions cannot overflow
    assign w_net = $signed({{2{iext_q[15]}}, iext_q}) - $signed({{2{ina_q[15]}}, ina_q})
                 - $signed({{2{ik_q[15]}}, ik_q}) - $signed({{2{il_q[15]}}, il_q});

    // 16x18 signed product always fits in 34 bits; >>> floors toward -inf
    assign w_prod  = $signed({{18{dt_q[15]}}, dt_q}) * $signed({{16{net_q[17]}}, net_q});
    assign w_delta = w_prod >>> C_SHIFT;

    assign w_sum = $signed({{20{V_q[15]}}, V_q}) + $signed({{2{delta_q[33]}}, delta_q});

    sat_s36_to_s16 u_sat (
        .in_i  (w_sum),
        .out_o (w_v_sat)
    );

    // Spike only on an upward crossing judged against the saturated result
    assign w_spike = (V_q < V_TH) && (w_v_sat >= V_TH);

`ifdef MEMBRANE_SPIKE_RESET_EN
    assign w_v_next = w_spike ? V_RESET : w_v_sat;
`else
    assign w_v_next = w_v_sat;
    logic w_unused_vreset;
    assign w_unused_vreset = ^V_RESET;
`endif

    // Step sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Step sequencer next state: only IDLE waits, and only for start
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SUM;
            SUM:     state_d = MUL;
            MUL:     state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands, then one pipeline stage per state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dt_q    <= '0;
            iext_q  <= '0;
            ina_q   <= '0;
            ik_q    <= '0;
            il_q    <= '0;
            net_q   <= '0;
            delta_q <= '0;
            V_q     <= V_INIT;
            done_q  <= 1'b0;
            spike_q <= 1'b0;
            count_q <= '0;
        end else begin
            done_q  <= 1'b0;
            spike_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dt_q   <= bus.dt;
                        iext_q <= bus.I_ext;
                        ina_q  <= bus.I_NA;
                        ik_q   <= bus.I_K;
                        il_q   <= bus.I_L;
                    end
                end
                SUM:   net_q   <= w_net;
                MUL:   delta_q <= w_delta;
                WRITE: begin
                    V_q     <= w_v_next;
                    done_q  <= 1'b1;
                    spike_q <= w_spike;
                    if (w_spike) begin
                        count_q <= count_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.V           = V_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.spike       = spike_q;
    assign bus.spike_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_membrane_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_membrane_update
// Description : Directed self-checking bench for membrane_update with
//               default parameters (V_INIT=-650, C_SHIFT=4, V_TH=0).
//               Expected values follow MEMBRANE_SPIKE_RESET_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_membrane_update;

`ifdef MEMBRANE_SPIKE_RESET_EN
    localparam bit SR = 1'b1;
`else
    localparam bit SR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    membrane_update_if bus_if ();

    membrane_update dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; leaves at a negedge with rst released
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #2;
        chk({tag, ".V"},     bus_if.V, -650);
        chk({tag, ".busy"},  bus_if.busy, 0);
        chk({tag, ".done"},  bus_if.done, 0);
        chk({tag, ".spike"}, bus_if.spike, 0);
        chk({tag, ".cnt"},   bus_if.spike_count, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One full step issued at a negedge; returns at a negedge
    task automatic step(input string tag, input logic signed [15:0] dt,
                        input logic signed [15:0] iext, input logic signed [15:0] ina,
                        input logic signed [15:0] ik, input logic signed [15:0] il,
                        input logic signed [31:0] exp_v, input logic exp_spk,
                        input logic signed [31:0] exp_cnt);
        int n;
        bus_if.dt    = dt;
        bus_if.I_ext = iext;
        bus_if.I_NA  = ina;
        bus_if.I_K   = ik;
        bus_if.I_L   = il;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.dt    = 16'($urandom);
        bus_if.I_ext = 16'($urandom);
        bus_if.I_NA  = 16'($urandom);
        bus_if.I_K   = 16'($urandom);
        bus_if.I_L   = 16'($urandom);
        chk({tag, ".busy_hi"}, bus_if.busy, 1);
        n = 0;
        while (n < 8 && bus_if.done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, n, 3);
        chk({tag, ".V"},       bus_if.V, exp_v);
        chk({tag, ".spike"},   bus_if.spike, exp_spk);
        chk({tag, ".cnt"},     bus_if.spike_count, exp_cnt);
        chk({tag, ".busy_lo"}, bus_if.busy, 0);
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        int first_at;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.dt    = '0;
        bus_if.I_ext = '0;
        bus_if.I_NA  = '0;
        bus_if.I_K   = '0;
        bus_if.I_L   = '0;
        @(negedge clk);

        // Basic step: delta = 16*100>>4 = 100
        do_reset("rst1");
        step("basic", 16, 100, 0, 0, 0, -550, 1'b0, 0);

        // Floor: 1*-1 = -1, >>>4 = -1
        do_reset("rst2");
        step("floor", 1, -1, 0, 0, 0, -651, 1'b0, 0);

        // Threshold crossing and no re-trigger
        do_reset("rst3");
        step("pre",    16, 600, 0, 0, 0, -50, 1'b0, 0);
        step("spike1", 16, 100, 0, 0, 0, SR ? -700 : 50, 1'b1, 1);
        step("spike2", 16, 100, 0, 0, 0, SR ? -600 : 150, 1'b0, 1);

        // Saturation: reach 32000 via I_NA, then large drive both ways
        do_reset("rst4");
        step("to32000", 16, 16325, -16325, 0, 0, SR ? -700 : 32000, 1'b1, 1);
        step("satpos", 32767, 32767, 0, 0, 0, SR ? -700 : 32767, SR, SR ? 2 : 1);
        step("satneg", 32767, -32768, 32767, 32767, 32767, -32768, 1'b0, SR ? 2 : 1);

        // start held high: back-to-back steps, one done every 4 cycles
        bus_if.dt    = 0;
        bus_if.I_ext = 0;
        bus_if.I_NA  = 0;
        bus_if.I_K   = 0;
        bus_if.I_L   = 0;
        bus_if.start = 1'b1;
        ndone    = 0;
        first_at = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done === 1'b1) begin
                ndone++;
                if (first_at < 0) first_at = i;
            end
        end
        bus_if.start = 1'b0;
        chk("held.ndone", ndone, 3);
        chk("held.first", first_at, 3);
        chk("held.V", bus_if.V, -32768);

        // start kept high through SUM, MUL, WRITE: only one step
        @(negedge clk);
        bus_if.dt    = 16;
        bus_if.I_ext = 100;
        bus_if.start = 1'b1;
        ndone    = 0;
        first_at = -1;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) begin
                ndone++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("ignore.ndone", ndone, 1);
        chk("ignore.first", first_at, 3);
        chk("ignore.V", bus_if.V, -32668);

        // Reset asserted while in MUL abandons the step
        @(negedge clk);
        bus_if.dt    = 16;
        bus_if.I_ext = 100;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst.V", bus_if.V, -650);
        chk("midrst.busy", bus_if.busy, 0);
        chk("midrst.done", bus_if.done, 0);
        chk("midrst.cnt", bus_if.spike_count, 0);
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done === 1'b1) ndone++;
        end
        chk("midrst.ndone", ndone, 0);
        chk("midrst.Vhold", bus_if.V, -650);
        chk("midrst.idle", bus_if.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
